// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - slot scanner driving a 3-to-8 decoder (sel/en), masked slots, programmable dwell
// Optional SCAN_BLANK_EN inserts one blank (en=0) cycle between consecutive active slots.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [7:0]         mask_q;
  logic               loop_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  logic [2:0] first_in, first_q, nxt_sel;
  logic       has_nxt, last_cycle;

  // Downward scans so the lowest qualifying index is the one that sticks.
  always_comb begin
    first_in = 3'd0;
    first_q  = 3'd0;
    nxt_sel  = 3'd0;
    has_nxt  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i])
        first_in = 3'(i);
      if (mask_q[i])
        first_q = 3'(i);
      if (mask_q[i] && (3'(i) > sel)) begin
        nxt_sel = 3'(i);
        has_nxt = 1'b1;
      end
    end
    last_cycle = (cnt == (dwell_q - ONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mask_q  <= 8'd0;
      loop_q  <= 1'b0;
      dwell_q <= ONE;
      cnt     <= '0;
      sel     <= 3'd0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        cnt   <= '0;
        sel   <= 3'd0;
        en    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (mask != 8'd0)) begin
              mask_q  <= mask;
              loop_q  <= loop;
              dwell_q <= (dwell == '0) ? ONE : dwell;
              cnt     <= '0;
              sel     <= first_in;
              en      <= 1'b1;
              busy    <= 1'b1;
              state   <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (!last_cycle) begin
              cnt <= cnt + ONE;
            end else begin
              cnt <= '0;
              if (has_nxt || loop_q) begin
                // A wrap back to the lowest slot marks the end of a looped frame.
                sel  <= has_nxt ? nxt_sel : first_q;
                done <= !has_nxt;
`ifdef SCAN_BLANK_EN
                state <= BLANK;
                en    <= 1'b0;
`endif
              end else begin
                state <= IDLE;
                sel   <= 3'd0;
                en    <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          BLANK: begin
            state <= ACTIVE;
            en    <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - scoreboard bench for decoder_scan_ctrl (follows SCAN_BLANK_EN if defined)
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       en, busy, done;

  // Expected per-cycle outputs packed as {en, sel, busy, done}.
  logic [5:0] exp_q[$];
  int total = 0;
  int bad   = 0;

`ifdef SCAN_BLANK_EN
  localparam bit BLANKS = 1'b1;
`else
  localparam bit BLANKS = 1'b0;
`endif

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .mask(mask), .dwell(dwell), .sel(sel), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic void push_frames(logic [7:0] m, logic [7:0] d, logic l, int nf);
    int slots[$];
    int dd;
    for (int i = 0; i < 8; i++)
      if (m[i]) slots.push_back(i);
    dd = (d == 8'd0) ? 1 : int'(d);
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < slots.size(); k++) begin
        if (BLANKS && (k > 0 || f > 0))
          exp_q.push_back({1'b0, 3'(slots[k]), 1'b1, (k == 0 && f > 0)});
        for (int c = 0; c < dd; c++)
          exp_q.push_back({1'b1, 3'(slots[k]), 1'b1, (!BLANKS && k == 0 && f > 0 && c == 0)});
      end
    end
    if (!l)
      exp_q.push_back(6'b0_000_0_1);
  endfunction

  task automatic start_scan(logic [7:0] m, logic [7:0] d, logic l);
    mask  = m;
    dwell = d;
    loop  = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mask  = 8'($urandom);
    dwell = 8'($urandom);
    loop  = ~l;
  endtask

  task automatic check_n(int n, string name, int poke);
    logic [5:0] e, got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {en, sel, busy, done};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b, required an expected entry (scoreboard empty)", name, i, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL %s cycle %0d: got {en,sel,busy,done}=%b required %b", name, i, got, e);
        end
      end
      start = (i == poke);
    end
    start = 1'b0;
  endtask

  task automatic check_idle(string name);
    logic [5:0] got;
    @(negedge clk);
    got = {en, sel, busy, done};
    total++;
    if (got !== 6'b0) begin
      bad++;
      $display("FAIL %s: got {en,sel,busy,done}=%b required 000000", name, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; mask = 8'hFF; dwell = 8'd1;
    repeat (2) @(posedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    check_idle("post_reset_idle");
  endtask

  task automatic test_full_mask();
    start_scan(8'hFF, 8'd2, 1'b0);
    push_frames(8'hFF, 8'd2, 1'b0, 1);
    check_n(exp_q.size(), "full_mask", 4);
    check_idle("full_mask_after");
  endtask

  task automatic test_sparse();
    start_scan(8'b1010_0100, 8'd3, 1'b0);
    push_frames(8'b1010_0100, 8'd3, 1'b0, 1);
    check_n(exp_q.size(), "sparse", -1);
  endtask

  task automatic test_zero_dwell();
    start_scan(8'h0F, 8'd0, 1'b0);
    push_frames(8'h0F, 8'd0, 1'b0, 1);
    check_n(exp_q.size(), "zero_dwell", -1);
  endtask

  task automatic test_loop_stop();
    start_scan(8'h81, 8'd1, 1'b1);
    push_frames(8'h81, 8'd1, 1'b1, 3);
    check_n(exp_q.size(), "loop", -1);
    stop = 1'b1;
    check_idle("stop_at_frame_end");
    stop = 1'b0;
    check_idle("stop_stays_idle");
  endtask

  task automatic test_single_loop();
    start_scan(8'h20, 8'd2, 1'b1);
    push_frames(8'h20, 8'd2, 1'b1, 3);
    check_n(exp_q.size(), "single_loop", -1);
    stop = 1'b1;
    check_idle("single_loop_stop");
    stop = 1'b0;
  endtask

  task automatic test_ignored_starts();
    start_scan(8'h00, 8'd2, 1'b0);
    check_idle("zero_mask_start");
    check_idle("zero_mask_start_2");
    stop = 1'b1;
    start_scan(8'hFF, 8'd2, 1'b0);
    stop = 1'b0;
    check_idle("start_with_stop");
    check_idle("start_with_stop_2");
  endtask

  task automatic test_reset_mid();
    int n;
    logic [5:0] e;
    start_scan(8'hFF, 8'd2, 1'b0);
    push_frames(8'hFF, 8'd2, 1'b0, 1);
    n = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (n == 0 && e[5] && e[4:2] == 3'd3) n = i + 1;
    end
    check_n(n, "pre_reset_slots", -1);
    rst = 1'b1;
    check_idle("reset_mid_scan");
    rst = 1'b0;
    exp_q.delete();
    check_idle("reset_mid_after");
  endtask

  task automatic test_back_to_back();
    start_scan(8'h10, 8'd1, 1'b0);
    push_frames(8'h10, 8'd1, 1'b0, 1);
    check_n(exp_q.size(), "b2b_first", -1);
    start_scan(8'h06, 8'd3, 1'b0);
    push_frames(8'h06, 8'd3, 1'b0, 1);
    check_n(exp_q.size(), "b2b_second", -1);
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse();
    test_zero_dwell();
    test_loop_stop();
    test_single_loop();
    test_ignored_starts();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequential scan controller that sits directly upstream of the 3-to-8 `decoder`. It drives the decoder's `in[2:0]` and `enable` to step through the eight output lines one slot at a time. Each slot is held for a programmable dwell time. Masked slots are skipped, and scanning runs as either a single frame or a continuous loop. Typical use is LED or keypad column scanning, with the decoder's one-hot `out[7:0]` driving the columns.

## Interface
- `DWELL_W`, default 8: width of the dwell-time input and the internal dwell counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `stop`  in  1  abort the scan; effective in any state.
- `loop`  in  1  0 = one frame, 1 = continuous; latched at start.
- `mask`  in  8  bit i = 1 enables slot i; latched at start.
- `dwell`  in  DWELL_W  cycles per slot; latched at start; 0 treated as 1.
- `sel`  out  3  slot index; connects to decoder `in`.
- `en`  out  1  slot active; connects to decoder `enable`.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse at the end of each completed frame.

## Operation
- States: IDLE, ACTIVE, plus BLANK when `SCAN_BLANK_EN` is defined.
- **IDLE**
  - Outputs: `sel=0`, `en=0`, `busy=0`.
  - On `start=1 && stop=0 && mask!=0`: latch `mask`, `loop`, and `dwell` (0→1). Go to ACTIVE with `sel` = lowest set bit of `mask`.
  - `start` with `mask==0`: ignored, remain in IDLE.
- **ACTIVE**
  - Outputs: `en=1`, `busy=1`. The dwell counter runs for exactly the latched dwell count of cycles.
  - At the final dwell cycle, the next slot is the next higher set mask bit.
  - If no higher set bit exists, the frame ends:
    - `loop=0`: go to IDLE and pulse `done`.
    - `loop=1`: wrap to the lowest set bit, pulse `done`, and continue.
- **BLANK** (macro only): one cycle with `en=0` and `busy=1`. `sel` already shows the next slot. It always returns to ACTIVE.
- Priority per cycle: `rst` > `stop` > slot/frame advance > `start`.
- `stop`:
  - Takes effect next cycle: IDLE, `sel=0`, `en=0`, `busy=0`.
  - No `done` pulse, including when `stop` coincides with frame end.
  - `start` and `stop` together in IDLE: stay in IDLE.
- `start` while busy is ignored. `mask`, `dwell` and `loop` changes while busy have no effect until the next start.
- Single-bit mask with `loop=1`: `sel` stays constant. `en` stays high, except for the blank cycle when the macro is defined. `done` pulses every dwell period.
- Reset values: `sel=0`, `en=0`, `busy=0`, `done=0`; state is IDLE and counter is 0. Reset mid-scan produces these values on the next cycle, with no `done`.

## Timing
- `start` sampled at edge T → `en=1`, `busy=1`, first `sel` valid from cycle T+1.
- Each ACTIVE slot holds `sel` for exactly D cycles, where D = max(dwell, 1).
- One-shot frame with N enabled slots and no macro: `en` is high for N·D consecutive cycles.
  - In the cycle after the last active cycle: `done=1`, `en=0`, `busy=0`.
- Loop mode: `done=1` in the first cycle of the wrapped slot. This is the blank cycle when the macro is defined.
- `stop` sampled at edge T → idle outputs from cycle T+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SCAN_BLANK_EN` defined:
  - One BLANK cycle (`en=0`) is inserted between consecutive ACTIVE slots, including at loop wrap, to avoid ghosting on the decoded lines.
  - No blank cycle after the final slot of a one-shot frame.
  - One-shot frame length becomes N·D + (N−1) cycles.
- `SCAN_BLANK_EN` not defined: slots are back-to-back and `en` stays high for the whole frame.

## Test plan
- Full mask, no macro: `mask=8'hFF`, `dwell=2`, `loop=0`, `start` → `sel` 0..7, each for 2 cycles, with `en=1` for 16 cycles. Then `done=1` for one cycle; `busy=0`, `en=0`.
- Sparse mask: `mask=8'b1010_0100`, `dwell=3` → `sel` visits 2, 5, 7, each for 3 cycles (9 active cycles), then `done`.
- Zero dwell: `dwell=0`, `mask=8'h0F` → `sel` 0, 1, 2, 3, each for 1 cycle, then `done`.
- Loop and stop:
  - `loop=1`, `mask=8'h81`, `dwell=1` → `sel` 0,7,0,7,… with `done` in each cycle `sel` returns to 0.
  - `stop` → next cycle `sel=0`, `en=0`, `busy=0`, no `done`.
- Ignored starts and reset:
  - `start` with `mask=0` → stays idle.
  - `start` and `stop` together → stays idle.
  - `rst` during slot 3 → all outputs 0 next cycle.
- Blank cycles: `SCAN_BLANK_EN` defined, `mask=8'h03`, `dwell=2` → (`en`,`sel`) = (1,0), (1,0), (0,1), (1,1), (1,1), then `done`.
